// File: rtl/shift_pkg.sv
// Shared types for the universal shift register:
// command codes and controller states.
package shift_pkg;

    typedef enum logic [2:0] {
        M_NOP  = 3'd0,
        M_LOAD = 3'd1,
        M_SHL  = 3'd2,
        M_SHR  = 3'd3,
        M_ROTL = 3'd4,
        M_ROTR = 3'd5,
        M_ASR  = 3'd6,
        M_RSVD = 3'd7
    } mode_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-bit move of the register for one shift step.
// Pure combinational; the controller decides when to apply it.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] next_q
);

    always_comb begin
        next_q = q;
        unique case (mode)
            M_SHL:   next_q = {q[WIDTH-2:0], sin_l};
            M_SHR:   next_q = {sin_r, q[WIDTH-1:1]};
            M_ROTL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ROTR:  next_q = {q[0], q[WIDTH-1:1]};
            M_ASR:   next_q = {q[WIDTH-1], q[WIDTH-1:1]};
            default: next_q = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: load, shift, rotate and arithmetic
// shift, moving one bit per cycle with busy/done handshake.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sclr,
    input  logic                       sset,
    input  logic                       start,
    input  logic [2:0]                 mode,
    input  logic [$clog2(WIDTH+1)-1:0] amount,
    input  logic [WIDTH-1:0]           din,
    input  logic                       sin_l,
    input  logic                       sin_r,
    output logic [WIDTH-1:0]           q,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(WIDTH+1);
    localparam logic [AW-1:0] WMAX = AW'(WIDTH);

    state_t           state, state_n;
    mode_t            mode_r, mode_n;
    logic [AW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] q_n, step_q;
    logic             done_n;
    mode_t            cmd;
    logic             is_load, is_mv;

    assign cmd     = mode_t'(mode);
    assign is_load = (cmd == M_LOAD);
    assign is_mv   = cmd inside {M_SHL, M_SHR, M_ROTL, M_ROTR, M_ASR};
    assign busy    = (state == S_SHIFT);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q      (q),
        .mode   (mode_r),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .next_q (step_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q      <= RESET_VAL;
            cnt    <= '0;
            mode_r <= M_NOP;
            done   <= 1'b0;
        end else begin
            q      <= q_n;
            cnt    <= cnt_n;
            mode_r <= mode_n;
            done   <= done_n;
        end
    end

    // Clears win over everything and silently drop a running command.
    always_comb begin
        state_n = state;
        q_n     = q;
        cnt_n   = cnt;
        mode_n  = mode_r;
        done_n  = 1'b0;
        if (sclr) begin
            q_n     = '0;
            cnt_n   = '0;
            state_n = S_IDLE;
        end else if (sset) begin
            q_n     = '1;
            cnt_n   = '0;
            state_n = S_IDLE;
        end else if (state == S_SHIFT) begin
            q_n   = step_q;
            cnt_n = cnt - 1'b1;
            if (cnt == AW'(1)) begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
        end else if (start) begin
            unique case (1'b1)
                is_load: begin
                    q_n    = din;
                    done_n = 1'b1;
                end
                (is_mv && amount != '0): begin
                    state_n = S_SHIFT;
                    mode_n  = cmd;
                    cnt_n   = (amount > WMAX) ? WMAX : amount;
                end
                default: done_n = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios
// plus randomized commands against a command-level model.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int AW = $clog2(W+1);

    logic          clk = 1'b0;
    logic          reset, sclr, sset, start, sin_l, sin_r;
    logic [2:0]    mode;
    logic [AW-1:0] amount;
    logic [W-1:0]  din, q;
    logic          busy, done;

    int passed = 0;
    int total  = 0;

    univ_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sclr   (sclr),
        .sset   (sset),
        .start  (start),
        .mode   (mode),
        .amount (amount),
        .din    (din),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q      (q),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int m, input int a, input logic [7:0] d);
        mode   = 3'(m);
        amount = AW'(a);
        din    = d;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Counts busy cycles after an accept, bounded.
    task automatic wait_done(output int n);
        int guard;
        n = 0;
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            if (busy === 1'b1) n++;
            guard++;
            tick();
        end
    endtask

    // One step of each mode written as plain byte arithmetic.
    function automatic logic [7:0] mstep(input logic [7:0] v, input int m,
                                         input logic sl, input logic sr);
        int x;
        x = int'(v);
        case (m)
            2: x = (x * 2 + int'(sl)) % 256;
            3: x = x / 2 + (sr ? 128 : 0);
            4: x = (x * 2) % 256 + x / 128;
            5: x = x / 2 + (x % 2) * 128;
            6: x = x / 2 + (x >= 128 ? 128 : 0);
            default: ;
        endcase
        return 8'(x);
    endfunction

    task automatic test_reset();
        reset = 1'b1; sclr = 0; sset = 0; start = 0;
        mode = 0; amount = 0; din = 0; sin_l = 0; sin_r = 0;
        #3;
        total++; if (q !== 8'h00) $display("FAIL reset_q got %h want 00", q); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        #5;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load();
        issue(1, 0, 8'hA5);
        total++; if (q !== 8'hA5) $display("FAIL load_q got %h want a5", q); else passed++;
        total++; if (done !== 1'b1) $display("FAIL load_done got %b want 1", done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL load_busy got %b want 0", busy); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL load_done_pulse got %b want 0", done); else passed++;
    endtask

    task automatic test_rotl();
        int n;
        issue(1, 0, 8'h81);
        tick();
        issue(4, 3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0)
                $display("FAIL rotl_busy cyc %0d got busy=%b done=%b want 1/0", i, busy, done);
            else passed++;
            tick();
        end
        total++; if (q !== 8'h0C) $display("FAIL rotl3_q got %h want 0c", q); else passed++;
        total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL rotl3_done got done=%b busy=%b want 1/0", done, busy);
        else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL rotl3_single_done got %b want 0", done); else passed++;
        issue(1, 0, 8'h81);
        tick();
        issue(4, 8, 8'h00);
        wait_done(n);
        total++; if (n !== 8) $display("FAIL rotl8_cycles got %0d want 8", n); else passed++;
        total++; if (q !== 8'h81) $display("FAIL rotl8_q got %h want 81", q); else passed++;
    endtask

    task automatic test_asr_shr();
        int n;
        issue(1, 0, 8'h90);
        tick();
        issue(6, 2, 8'h00);
        wait_done(n);
        total++; if (q !== 8'hE4) $display("FAIL asr2_q got %h want e4", q); else passed++;
        total++; if (n !== 2) $display("FAIL asr2_cycles got %0d want 2", n); else passed++;
        sin_r = 1'b0;
        issue(3, 9, 8'h00);
        wait_done(n);
        total++; if (n !== 8) $display("FAIL shr9_cycles got %0d want 8", n); else passed++;
        total++; if (q !== 8'h00) $display("FAIL shr9_q got %h want 00", q); else passed++;
        total++; if (done !== 1'b1) $display("FAIL shr9_done got %b want 1", done); else passed++;
    endtask

    task automatic test_sclr_abort();
        issue(1, 0, 8'h01);
        tick();
        sin_l = 1'b1;
        issue(2, 5, 8'h00);
        // start during busy must be ignored
        mode = 3'd1; din = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (q !== 8'h03) $display("FAIL shl_ignore_start got %h want 03", q); else passed++;
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        total++; if (q !== 8'h00) $display("FAIL sclr_q got %h want 00", q); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL sclr_busy got %b want 0", busy); else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (done !== 1'b0 || q !== 8'h00)
                $display("FAIL sclr_no_done cyc %0d got done=%b q=%h want 0/00", i, done, q);
            else passed++;
            tick();
        end
        sin_l = 1'b0;
    endtask

    task automatic test_sset();
        sset = 1'b1;
        issue(1, 0, 8'h12);
        sset = 1'b0;
        total++; if (q !== 8'hFF) $display("FAIL sset_q got %h want ff", q); else passed++;
        total++; if (done !== 1'b0) $display("FAIL sset_done got %b want 0", done); else passed++;
        sclr = 1'b1; sset = 1'b1;
        tick();
        sclr = 1'b0; sset = 1'b0;
        total++; if (q !== 8'h00) $display("FAIL sclr_over_sset got %h want 00", q); else passed++;
        issue(1, 0, 8'h0F);
        tick();
        issue(5, 6, 8'h00);
        tick();
        sset = 1'b1;
        tick();
        sset = 1'b0;
        total++;
        if (q !== 8'hFF || busy !== 1'b0)
            $display("FAIL sset_abort got q=%h busy=%b want ff/0", q, busy);
        else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL sset_abort_done got %b want 0", done); else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        issue(1, 0, 8'h40);
        tick();
        issue(4, 2, 8'h00);
        wait_done(n);
        total++; if (q !== 8'h01) $display("FAIL b2b_rotl_q got %h want 01", q); else passed++;
        issue(1, 0, 8'h77);
        total++; if (q !== 8'h77) $display("FAIL b2b_load_q got %h want 77", q); else passed++;
        total++; if (done !== 1'b1) $display("FAIL b2b_load_done got %b want 1", done); else passed++;
        issue(0, 0, 8'h00);
        total++;
        if (done !== 1'b1 || q !== 8'h77)
            $display("FAIL b2b_nop got done=%b q=%h want 1/77", done, q);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        issue(1, 0, 8'h5A);
        tick();
        issue(5, 6, 8'h00);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        total++; if (q !== 8'h00) $display("FAIL rst_mid_q got %h want 00", q); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst_mid_done got %b want 0", done); else passed++;
        @(negedge clk);
        reset = 1'b0;
        mode = 3'd1; din = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (q !== 8'h3C) $display("FAIL rst_release_accept got %h want 3c", q); else passed++;
        total++; if (done !== 1'b1) $display("FAIL rst_release_done got %b want 1", done); else passed++;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] model;
        logic [7:0] d;
        int m, a, steps;
        logic sl, sr;
        model = 8'($urandom);
        issue(1, 0, model);
        tick();
        for (int c = 0; c < 40; c++) begin
            m = $urandom_range(0, 7);
            a = $urandom_range(0, 15);
            d = 8'($urandom);
            issue(m, a, d);
            if (m == 1) model = d;
            steps = (m >= 2 && m <= 6) ? ((a > W) ? W : a) : 0;
            for (int k = 0; k < steps; k++) begin
                sl = 1'($urandom);
                sr = 1'($urandom);
                sin_l = sl;
                sin_r = sr;
                start = 1'($urandom);
                mode  = 3'($urandom);
                din   = 8'($urandom);
                total++;
                if (busy !== 1'b1 || done !== 1'b0)
                    $display("FAIL rand_busy cmd %0d step %0d got busy=%b done=%b", c, k, busy, done);
                else passed++;
                tick();
                model = mstep(model, m, sl, sr);
            end
            start = 1'b0;
            total++;
            if (q !== model || done !== 1'b1 || busy !== 1'b0)
                $display("FAIL rand_cmd %0d m=%0d a=%0d got q=%h done=%b busy=%b want q=%h 1/0",
                         c, m, a, q, done, busy, model);
            else passed++;
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_rotl();
        test_asr_shr();
        test_sclr_abort();
        test_sset();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
